mdu_ctrl: RTL and testbench

- Sequencing controller for the execute-stage multiply/divide unit and its HI/LO registers.
- Accepts a mult/div/move op from E and models fixed multi-cycle latency with a down-counter.
- Drives HI/LO and raises a stall request to the pipeline while any MDU-using instruction is held in D.
- Sits beside the ALU in E; results feed the E→M pipeline register via mfhi/mflo selection.

---
 rtl/mdu_ctrl_if.sv | 28 ++
 rtl/mdu_ctrl.sv | 138 +++++++++++++
 tb/tb_mdu_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Handshake/result bundle between the E-stage pipeline and the MDU sequencer.
// Optional MDU_INT_CANCEL_EN adds the cancel line from the M-stage exception logic.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req_md_D;
`ifdef MDU_INT_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MDU_INT_CANCEL_EN
    modport master (output start, md_op, rs_val, rt_val, req_md_D, cancel,
                    input  busy, stall_md, hi, lo);
    modport slave  (input  start, md_op, rs_val, rt_val, req_md_D, cancel,
                    output busy, stall_md, hi, lo);
`else
    modport master (output start, md_op, rs_val, rt_val, req_md_D,
                    input  busy, stall_md, hi, lo);
    modport slave  (input  start, md_op, rs_val, rt_val, req_md_D,
                    output busy, stall_md, hi, lo);
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// MDU sequencer: computes mult/div results at issue, holds them in pending
// registers, and commits HI/LO after a fixed busy window counted down in RUN.
// Optional feature macro: MDU_INT_CANCEL_EN (adds a cancel input that aborts
// a running op or suppresses a start without touching HI/LO).
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);
    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic { IDLE, RUN } state_t;
    typedef enum logic [2:0] {
        OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
        OP_MTHI = 3'd4, OP_MTLO  = 3'd5, OP_NOP6 = 3'd6, OP_NOP7 = 3'd7
    } md_op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic               cancel_w;

`ifdef MDU_INT_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Datapath: all four results computed from the current operands.
    logic [63:0] prod_s, prod_u;
    logic [31:0] rs_mag, rt_mag, den_s, den_u;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic        rt_nz;

    // Signed ops work on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        rt_nz   = |bus.rt_val;
        prod_s  = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
        prod_u  = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
        rs_mag  = bus.rs_val[31] ? -bus.rs_val : bus.rs_val;
        rt_mag  = bus.rt_val[31] ? -bus.rt_val : bus.rt_val;
        // Divisor of zero is replaced by one; the result is discarded anyway.
        den_s   = rt_nz ? rt_mag : 32'd1;
        den_u   = rt_nz ? bus.rt_val : 32'd1;
        quo_mag = rs_mag / den_s;
        rem_mag = rs_mag % den_s;
        quo_s   = (bus.rs_val[31] ^ bus.rt_val[31]) ? -quo_mag : quo_mag;
        rem_s   = bus.rs_val[31] ? -rem_mag : rem_mag;
        quo_u   = bus.rs_val / den_u;
        rem_u   = bus.rs_val % den_u;
    end

    // Next-state: issue in IDLE, count down and commit in RUN.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !cancel_w) begin
                    unique case (md_op_t'(bus.md_op))
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = (bus.md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                            pend_lo_d = (bus.md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = (bus.md_op == OP_DIV) ? rem_s : rem_u;
                            pend_lo_d = (bus.md_op == OP_DIV) ? quo_s : quo_u;
                            pend_wr_d = rt_nz;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel_w) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; pending results are cleared too.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.stall_md = bus.req_md_D & (bus.start | bus.busy);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan steps followed by
// random ops, all checked against an arithmetic reference model.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi, m_lo;

    mdu_ctrl_if mif ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural effect of one op on HI/LO.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic wr, output logic [31:0] nh, output logic [31:0] nl);
        int               ia, ib;
        longint           sa, sb, sq, sr;
        longint unsigned  ua, ub;
        logic [63:0]      p;
        ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
        wr = 1'b0; nh = m_hi; nl = m_lo;
        case (op)
            3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; wr = 1'b1; end
            3'd1: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; wr = 1'b1; end
            3'd2: if (b != 0) begin
                      sq = sa / sb; sr = sa % sb;
                      nl = sq[31:0]; nh = sr[31:0]; wr = 1'b1;
                  end
            3'd3: if (b != 0) begin nl = a / b; nh = a % b; wr = 1'b1; end
            3'd4: begin nh = a; wr = 1'b1; end
            3'd5: begin nl = a; wr = 1'b1; end
            default: ;
        endcase
    endfunction

    // Issue one op, watch the busy window, then compare HI/LO with the model.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, input bit poke);
        logic        wr;
        logic [31:0] nh, nl;
        int          n, exp_n;
        model(op, a, b, wr, nh, nl);
        exp_n = (op < 3'd2) ? 5 : (op < 3'd4) ? 10 : 0;
        @(negedge clk);
        mif.start = 1'b1; mif.md_op = op; mif.rs_val = a; mif.rt_val = b; mif.req_md_D = req;
        #1 check("stall_at_start", mif.stall_md, req);
        @(negedge clk);
        mif.start = 1'b0;
        #1;
        n = 0;
        while (mif.busy === 1'b1 && n < 40) begin
            check("stall_busy", mif.stall_md, req);
            check("hi_hold", mif.hi, m_hi);
            check("lo_hold", mif.lo, m_lo);
            @(negedge clk);
            if (poke && n == 1) begin
                mif.start = 1'b1; mif.md_op = 3'd0; mif.rs_val = $urandom; mif.rt_val = $urandom;
            end else begin
                mif.start = 1'b0;
            end
            #1;
            n++;
        end
        check("busy_cycles", n, exp_n);
        check("busy_low", mif.busy, 1'b0);
        check("stall_low", mif.stall_md, 1'b0);
        if (wr) begin m_hi = nh; m_lo = nl; end
        check("hi", mif.hi, m_hi);
        check("lo", mif.lo, m_lo);
        mif.req_md_D = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b1;
        mif.start = 1'b0; mif.md_op = 3'd7; mif.rs_val = '0; mif.rt_val = '0; mif.req_md_D = 1'b0;
`ifdef MDU_INT_CANCEL_EN
        mif.cancel = 1'b0;
`endif
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", mif.busy, 1'b0);
        check("rst_hi", mif.hi, 32'h0);
        check("rst_lo", mif.lo, 32'h0);
        check("rst_stall", mif.stall_md, 1'b0);

        // MULT -3 * 5 with the stall request held.
        do_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        check("mult_hi_const", mif.hi, 32'hFFFFFFFF);
        check("mult_lo_const", mif.lo, 32'hFFFFFFF1);
        // DIVU 7/2, stall not requested; a start is poked mid-run.
        do_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b1);
        check("divu_lo_const", mif.lo, 32'd3);
        check("divu_hi_const", mif.hi, 32'd1);
        // DIV -7/2.
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        check("div_lo_const", mif.lo, 32'hFFFFFFFD);
        check("div_hi_const", mif.hi, 32'hFFFFFFFF);
        // MTHI leaves LO alone.
        do_op(3'd4, 32'h12345678, 32'd0, 1'b0, 1'b0);
        check("mthi_const", mif.hi, 32'h12345678);
        check("mthi_lo_const", mif.lo, 32'hFFFFFFFD);
        // Divide by zero keeps preset HI/LO.
        do_op(3'd4, 32'hA, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'hB, 32'd0, 1'b0, 1'b0);
        do_op(3'd2, 32'd99, 32'd0, 1'b1, 1'b0);
        check("div0_hi_const", mif.hi, 32'hA);
        check("div0_lo_const", mif.lo, 32'hB);
        // Overflowing signed divide.
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("divovf_lo_const", mif.lo, 32'h80000000);
        check("divovf_hi_const", mif.hi, 32'h0);
        // No-op codes.
        do_op(3'd6, 32'h55, 32'h66, 1'b1, 1'b0);

        // Reset in the third busy cycle of a MULT.
        do_op(3'd4, 32'hCAFE, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        mif.start = 1'b1; mif.md_op = 3'd0; mif.rs_val = 32'd3; mif.rt_val = 32'd4;
        @(negedge clk); mif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("busy_before_rst", mif.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", mif.busy, 1'b0);
        check("midrst_hi", mif.hi, 32'h0);
        check("midrst_lo", mif.lo, 32'h0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (8) @(negedge clk);
        #1;
        check("postrst_hi", mif.hi, 32'h0);
        check("postrst_busy", mif.busy, 1'b0);

`ifdef MDU_INT_CANCEL_EN
        // Cancel in the third busy cycle keeps prior HI/LO.
        do_op(3'd4, 32'h1111, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h2222, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        mif.start = 1'b1; mif.md_op = 3'd0; mif.rs_val = 32'd7; mif.rt_val = 32'd9;
        @(negedge clk); mif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mif.cancel = 1'b1;
        @(negedge clk);
        mif.cancel = 1'b0;
        #1;
        check("cancel_busy", mif.busy, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        check("cancel_hi", mif.hi, 32'h1111);
        check("cancel_lo", mif.lo, 32'h2222);
        // Cancel suppresses an MTHI in IDLE.
        @(negedge clk);
        mif.start = 1'b1; mif.md_op = 3'd4; mif.rs_val = 32'hDEAD; mif.cancel = 1'b1;
        @(negedge clk);
        mif.start = 1'b0; mif.cancel = 1'b0;
        #1;
        check("cancel_mthi", mif.hi, 32'h1111);
        check("cancel_start_busy", mif.busy, 1'b0);
`endif

        // Random ops against the model.
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
